uart_cmd_ctrl: RTL and testbench

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

---
 rtl/uart_cmd_ctrl.sv | 126 ++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART byte-stream command framer producing register writes.
// Define UART_CMD_CHK_EN to require a trailing XOR checksum byte (5-byte frames).
module uart_cmd_ctrl #(
    parameter int         TIMEOUT = 17360,
    parameter logic [7:0] SYNC    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_err,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        busy
);

    localparam int            GW       = $clog2(TIMEOUT + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DH,
        S_DL,
        S_CHK
    } state_t;

    state_t        state;
    logic [GW-1:0] gap;
    logic [7:0]    addr_q;
    logic [7:0]    dh_q;
`ifdef UART_CMD_CHK_EN
    logic [7:0]    dl_q;
`endif

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            gap       <= '0;
            addr_q    <= '0;
            dh_q      <= '0;
`ifdef UART_CMD_CHK_EN
            dl_q      <= '0;
`endif
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            wr_en     <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            // A receiver error outranks any byte presented in the same cycle.
            if (rx_err) begin
                frame_err <= 1'b1;
                err_code  <= 2'b01;
                state     <= S_IDLE;
                gap       <= '0;
            end else if (rx_valid) begin
                gap <= '0;
                case (state)
                    S_IDLE: begin
                        if (rx_data == SYNC) state <= S_ADDR;
                    end
                    S_ADDR: begin
                        addr_q <= rx_data;
                        state  <= S_DH;
                    end
                    S_DH: begin
                        dh_q  <= rx_data;
                        state <= S_DL;
                    end
`ifdef UART_CMD_CHK_EN
                    S_DL: begin
                        dl_q  <= rx_data;
                        state <= S_CHK;
                    end
                    S_CHK: begin
                        if (rx_data == (addr_q ^ dh_q ^ dl_q)) begin
                            wr_en    <= 1'b1;
                            frame_ok <= 1'b1;
                            wr_addr  <= addr_q;
                            wr_data  <= {dh_q, dl_q};
                            err_code <= 2'b00;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= 2'b10;
                        end
                        state <= S_IDLE;
                    end
`else
                    S_DL: begin
                        wr_en    <= 1'b1;
                        frame_ok <= 1'b1;
                        wr_addr  <= addr_q;
                        wr_data  <= {dh_q, rx_data};
                        err_code <= 2'b00;
                        state    <= S_IDLE;
                    end
`endif
                    default: state <= S_IDLE;
                endcase
            end else if (state != S_IDLE) begin
                if (gap == GAP_LAST) begin
                    frame_err <= 1'b1;
                    err_code  <= 2'b11;
                    state     <= S_IDLE;
                    gap       <= '0;
                end else begin
                    gap <= gap + GW'(1);
                end
            end else begin
                gap <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - scoreboard bench for uart_cmd_ctrl (both frame formats).
module tb_uart_cmd_ctrl;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_err;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        frame_ok;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          is_err;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [1:0]  code;
    } exp_t;

    exp_t exp_q[$];

    uart_cmd_ctrl #(.TIMEOUT(TO), .SYNC(8'hA5)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_err    (rx_err),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [15:0] d);
        exp_t e;
        e.is_err = 1'b0; e.addr = a; e.data = d; e.code = 2'b00;
        exp_q.push_back(e);
    endtask

    task automatic push_err(input logic [1:0] c);
        exp_t e;
        e.is_err = 1'b1; e.addr = '0; e.data = '0; e.code = c;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic err_pulse(input bit with_valid, input logic [7:0] b);
        rx_err   = 1'b1;
        rx_valid = with_valid;
        rx_data  = b;
        @(posedge clk); #1;
        rx_err   = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] dh, input logic [7:0] dl);
        send(8'hA5);
        send(a);
        send(dh);
`ifdef UART_CMD_CHK_EN
        send(dl);
        push_wr(a, {dh, dl});
        send(a ^ dh ^ dl);
`else
        push_wr(a, {dh, dl});
        send(dl);
`endif
    endtask

    // Monitor: every output pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (wr_en || frame_ok || frame_err) begin
            exp_t e;
            check("pulse_exclusive", {30'd0, frame_err && (wr_en || frame_ok), wr_en != frame_ok}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse actual wr_en=%0b frame_err=%0b err_code=%0d required no pulse",
                         wr_en, frame_err, err_code);
            end else begin
                e = exp_q.pop_front();
                if (e.is_err) begin
                    check("err_pulse", {31'd0, frame_err}, 32'd1);
                    check("err_code", {30'd0, err_code}, {30'd0, e.code});
                end else begin
                    check("wr_pulse", {31'd0, wr_en}, 32'd1);
                    check("wr_addr", {24'd0, wr_addr}, {24'd0, e.addr});
                    check("wr_data", {16'd0, wr_data}, {16'd0, e.data});
                    check("ok_code", {30'd0, err_code}, 32'd0);
                end
            end
        end
    end

    initial begin
        rst      = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        #12;
        check("rst_outputs", {wr_en, frame_ok, frame_err, busy, err_code}, 32'd0);
        check("rst_wr", {8'd0, wr_addr, wr_data}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // First frame straight out of reset.
        frame(8'h12, 8'hBE, 8'hEF);
        idle(2);
        check("busy_after_ok", {31'd0, busy}, 32'd0);

`ifdef UART_CMD_CHK_EN
        send(8'hA5); send(8'h12); send(8'hBE); send(8'hEF);
        push_err(2'b10);
        send(8'h44);
        idle(2);
        check("badchk_code", {30'd0, err_code}, 32'd2);
        check("badchk_hold", {8'd0, wr_addr, wr_data}, {8'd0, 8'h12, 16'hBEEF});
`endif

        // Leading noise, then a frame; trailing 03 is the CHK or idle noise.
        send(8'h00); send(8'hFF); send(8'hA5); send(8'h01); send(8'h00);
`ifdef UART_CMD_CHK_EN
        send(8'h02);
        push_wr(8'h01, 16'h0002);
        send(8'h03);
`else
        push_wr(8'h01, 16'h0002);
        send(8'h02);
        send(8'h03);
`endif
        idle(2);
        check("noise_code", {30'd0, err_code}, 32'd0);

        // rx_err while in DH.
        send(8'hA5); send(8'h12);
        push_err(2'b01);
        err_pulse(1'b0, 8'h00);
        idle(2);
        check("rxerr_code", {30'd0, err_code}, 32'd1);
        check("rxerr_hold", {8'd0, wr_addr, wr_data}, {8'd0, 8'h01, 16'h0002});

        // rx_err with a coincident SYNC: the byte is dropped, rest is noise.
        push_err(2'b01);
        err_pulse(1'b1, 8'hA5);
        send(8'h12); send(8'hBE); send(8'hEF); send(8'h43);
        idle(2);
        check("rxerr_sync_busy", {31'd0, busy}, 32'd0);

        // Gap timeout.
        send(8'hA5); send(8'h12);
        push_err(2'b11);
        idle(TO);
        check("timeout_busy", {31'd0, busy}, 32'd0);
        check("timeout_code", {30'd0, err_code}, 32'd3);
        frame(8'h34, 8'h56, 8'h78);
        idle(2);

        // Byte arrives on the very cycle the timeout would fire.
        send(8'hA5); send(8'h12);
        idle(TO - 1);
        send(8'hBE);
`ifdef UART_CMD_CHK_EN
        send(8'hEF);
        push_wr(8'h12, 16'hBEEF);
        send(8'h43);
`else
        push_wr(8'h12, 16'hBEEF);
        send(8'hEF);
`endif
        idle(2);
        check("coincident_code", {30'd0, err_code}, 32'd0);

        // Reset asserted while in DL.
        send(8'hA5); send(8'h12); send(8'hBE);
        check("busy_in_dl", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_outputs", {wr_en, frame_ok, frame_err, busy, err_code}, 32'd0);
        check("midrst_wr", {8'd0, wr_addr, wr_data}, 32'd0);
        idle(3);
        rst = 1'b1;
        frame(8'h9A, 8'hBC, 8'hDE);
        idle(5);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
